// File: rtl/serializer_pkg.sv
// serializer_pkg
// Shared types and constants for the parametrised unit-cell serializer.
//   ser_state_t      : shifter FSM states
//   DATA_W_DEFAULT   : default word width
//   IDLE_BIT_DEFAULT : default line level when nothing is being shifted
//   cnt_width()      : width of the bit counter for a given word width
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int   DATA_W_DEFAULT   = 16;
  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  // The counter must reach DATA_W-1; $clog2 of a power of two gives exactly that.
  function automatic int cnt_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/serializer_hold_buf.sv
// serializer_hold_buf
// One-entry holding register for {LSB_FIRST, PAR_IN} with a valid/ready
// front end. The shifter FSM empties it through the pop strobe.
//   CLK, RESET        : clock, synchronous active-high reset
//   PAR_IN, LSB_FIRST : word and bit order captured on acceptance
//   PAR_VALID         : source offers a word
//   PAR_READY         : registered, high while the buffer is empty
//   pop               : shifter takes the held word on this edge
//   full              : buffer holds a word
//   hold_word         : held word
//   hold_lsb_first    : bit order captured with the held word
module serializer_hold_buf
  import serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] PAR_IN,
  input  logic              LSB_FIRST,
  input  logic              PAR_VALID,
  output logic              PAR_READY,
  input  logic              pop,
  output logic              full,
  output logic [DATA_W-1:0] hold_word,
  output logic              hold_lsb_first
);

  logic accept;
  logic full_next;

  // Accept requires empty and pop requires full, so they never coincide.
  assign accept    = PAR_VALID && PAR_READY;
  assign full_next = (full && !pop) || accept;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      full           <= 1'b0;
      PAR_READY      <= 1'b1;
      hold_word      <= '0;
      hold_lsb_first <= 1'b0;
    end else begin
      full      <= full_next;
      PAR_READY <= !full_next;
      if (accept) begin
        hold_word      <= PAR_IN;
        hold_lsb_first <= LSB_FIRST;
      end
    end
  end

endmodule

// File: rtl/serializer_unit_cell_gen.sv
// serializer_unit_cell_gen
// Streaming parallel-to-serial converter. Words enter through a one-entry
// holding buffer and are shifted out one bit per CLK, in the order captured
// with each word. A word waiting in the buffer is loaded on the edge after
// the current last bit, so back-to-back words stream without gaps.
//   CLK, RESET   : clock, synchronous active-high reset
//   PAR_IN       : parallel word, sampled when PAR_VALID && PAR_READY
//   PAR_VALID    : source has a word
//   PAR_READY    : holding buffer empty (registered)
//   LSB_FIRST    : 1 = bit 0 first, 0 = bit DATA_W-1 first (per word)
//   SERIAL_OUT   : registered serial data, IDLE_BIT when not shifting
//   SERIAL_VALID : SERIAL_OUT carries a data bit
//   FRAME_START  : SERIAL_OUT carries the first bit of a word
//   BUSY         : buffer or shifter holds data
module serializer_unit_cell_gen
  import serializer_pkg::*;
#(
  parameter int   DATA_W   = DATA_W_DEFAULT,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] PAR_IN,
  input  logic              PAR_VALID,
  output logic              PAR_READY,
  input  logic              LSB_FIRST,
  output logic              SERIAL_OUT,
  output logic              SERIAL_VALID,
  output logic              FRAME_START,
  output logic              BUSY
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  ser_state_t        state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              order, order_next;
  logic              out_next, valid_next, fs_next;
  logic              load;
  logic              hold_full;
  logic [DATA_W-1:0] hold_word;
  logic              hold_lsb_first;

  serializer_hold_buf #(
    .DATA_W(DATA_W)
  ) u_hold_buf (
    .CLK           (CLK),
    .RESET         (RESET),
    .PAR_IN        (PAR_IN),
    .LSB_FIRST     (LSB_FIRST),
    .PAR_VALID     (PAR_VALID),
    .PAR_READY     (PAR_READY),
    .pop           (load),
    .full          (hold_full),
    .hold_word     (hold_word),
    .hold_lsb_first(hold_lsb_first)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      order        <= 1'b0;
      SERIAL_OUT   <= IDLE_BIT;
      SERIAL_VALID <= 1'b0;
      FRAME_START  <= 1'b0;
    end else begin
      state        <= state_next;
      shreg        <= shreg_next;
      cnt          <= cnt_next;
      order        <= order_next;
      SERIAL_OUT   <= out_next;
      SERIAL_VALID <= valid_next;
      FRAME_START  <= fs_next;
    end
  end

  // SERIAL_OUT is registered, so a load drives the first bit straight from
  // the held word and the shifter keeps only the remaining bits.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    order_next = order;
    out_next   = SERIAL_OUT;
    valid_next = SERIAL_VALID;
    fs_next    = 1'b0;
    load       = 1'b0;

    case (state)
      IDLE: begin
        out_next   = IDLE_BIT;
        valid_next = 1'b0;
        load       = hold_full;
      end
      SHIFT: begin
        if (cnt == LAST_CNT) begin
          if (hold_full) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
            out_next   = IDLE_BIT;
            valid_next = 1'b0;
          end
        end else begin
          out_next   = order ? shreg[0] : shreg[DATA_W-1];
          shreg_next = order ? (shreg >> 1) : (shreg << 1);
          cnt_next   = cnt + 1'b1;
          valid_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        out_next   = IDLE_BIT;
        valid_next = 1'b0;
      end
    endcase

    if (load) begin
      state_next = SHIFT;
      order_next = hold_lsb_first;
      out_next   = hold_lsb_first ? hold_word[0] : hold_word[DATA_W-1];
      shreg_next = hold_lsb_first ? (hold_word >> 1) : (hold_word << 1);
      cnt_next   = '0;
      valid_next = 1'b1;
      fs_next    = 1'b1;
    end
  end

  assign BUSY = hold_full || (state == SHIFT);

endmodule

// File: tb/tb_serializer_unit_cell_gen.sv
module tb_serializer_unit_cell_gen;

  logic        CLK;
  logic        RESET;
  logic [15:0] PAR_IN;
  logic        PAR_VALID;
  logic        PAR_READY;
  logic        LSB_FIRST;
  logic        SERIAL_OUT;
  logic        SERIAL_VALID;
  logic        FRAME_START;
  logic        BUSY;

  int n_cmp;
  int n_fail;

  serializer_unit_cell_gen #(
    .DATA_W  (16),
    .IDLE_BIT(1'b0)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PAR_IN      (PAR_IN),
    .PAR_VALID   (PAR_VALID),
    .PAR_READY   (PAR_READY),
    .LSB_FIRST   (LSB_FIRST),
    .SERIAL_OUT  (SERIAL_OUT),
    .SERIAL_VALID(SERIAL_VALID),
    .FRAME_START (FRAME_START),
    .BUSY        (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    PAR_VALID = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({SERIAL_OUT, SERIAL_VALID, FRAME_START, PAR_READY, BUSY} !== 5'b00010) begin
        n_fail++;
        $display("[TB] FAIL reset_idle cyc %0d: got out/val/fs/rdy/busy=%b required 00010", i,
                 {SERIAL_OUT, SERIAL_VALID, FRAME_START, PAR_READY, BUSY});
      end
    end
  endtask

  // seq[15] is the first expected serial bit.
  task automatic test_single_word(input logic [15:0] word, input logic lsb,
                                  input logic [15:0] seq);
    PAR_IN = word;
    LSB_FIRST = lsb;
    PAR_VALID = 1'b1;
    tick();
    PAR_VALID = 1'b0;
    n_cmp++;
    if ({PAR_READY, BUSY, SERIAL_VALID} !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL single_accept lsb=%0d: got rdy/busy/val=%b required 010", lsb,
               {PAR_READY, BUSY, SERIAL_VALID});
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      n_cmp++;
      if ({SERIAL_OUT, SERIAL_VALID, FRAME_START} !== {seq[15-i], 1'b1, (i == 0)}) begin
        n_fail++;
        $display("[TB] FAIL single_bit lsb=%0d idx %0d: got out/val/fs=%b required %b", lsb, i,
                 {SERIAL_OUT, SERIAL_VALID, FRAME_START}, {seq[15-i], 1'b1, (i == 0)});
      end
      if (i == 0) begin
        n_cmp++;
        if (PAR_READY !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL single_ready_return: got %b required 1", PAR_READY);
        end
      end
    end
    tick();
    n_cmp++;
    if ({SERIAL_OUT, SERIAL_VALID, FRAME_START, BUSY} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL single_idle_after lsb=%0d: got out/val/fs/busy=%b required 0000", lsb,
               {SERIAL_OUT, SERIAL_VALID, FRAME_START, BUSY});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    int k, nvalid;
    logic rdy, exp_bit;
    words[0] = 16'h0001;
    words[1] = 16'h8000;
    words[2] = 16'hFFFF;
    k = 0;
    nvalid = 0;
    LSB_FIRST = 1'b1;
    PAR_IN = words[0];
    PAR_VALID = 1'b1;
    for (int c = 0; c < 80; c++) begin
      rdy = PAR_READY;
      tick();
      if (PAR_VALID && rdy) begin
        n_cmp++;
        if (PAR_READY !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL b2b_ready_low word %0d: got %b required 0", k, PAR_READY);
        end
        k++;
        if (k < 3) PAR_IN = words[k];
        else PAR_VALID = 1'b0;
      end
      if (SERIAL_VALID) begin
        exp_bit = (nvalid == 0) || (nvalid >= 31);
        n_cmp++;
        if ({SERIAL_OUT, FRAME_START, BUSY} !==
            {exp_bit, (nvalid == 0 || nvalid == 16 || nvalid == 32), 1'b1}) begin
          n_fail++;
          $display("[TB] FAIL b2b_bit idx %0d: got out/fs/busy=%b required %b", nvalid,
                   {SERIAL_OUT, FRAME_START, BUSY},
                   {exp_bit, (nvalid == 0 || nvalid == 16 || nvalid == 32), 1'b1});
        end
        nvalid++;
      end else if (nvalid > 0 && nvalid < 48) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL b2b_gap after %0d bits: got valid 0 required 1", nvalid);
        break;
      end
      if (nvalid == 48 && !SERIAL_VALID) break;
    end
    PAR_VALID = 1'b0;
    n_cmp++;
    if (nvalid !== 48) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d bits required 48", nvalid);
    end
  endtask

  task automatic test_order_mix();
    logic [31:0] stream;
    int k, nvalid;
    logic rdy;
    stream = '0;
    k = 0;
    nvalid = 0;
    PAR_IN = 16'h0001;
    LSB_FIRST = 1'b1;
    PAR_VALID = 1'b1;
    for (int c = 0; c < 60 && nvalid < 32; c++) begin
      rdy = PAR_READY;
      tick();
      if (PAR_VALID && rdy) begin
        k++;
        if (k == 1) begin
          PAR_IN = 16'h0001;
          LSB_FIRST = 1'b0;
        end else begin
          PAR_VALID = 1'b0;
          LSB_FIRST = 1'b1;
          PAR_IN = 16'hFFFF;
        end
      end
      if (SERIAL_VALID) begin
        stream[nvalid] = SERIAL_OUT;
        n_cmp++;
        if (FRAME_START !== (nvalid == 0 || nvalid == 16)) begin
          n_fail++;
          $display("[TB] FAIL mix_frame idx %0d: got %b required %b", nvalid, FRAME_START,
                   (nvalid == 0 || nvalid == 16));
        end
        nvalid++;
      end
    end
    n_cmp++;
    if (stream !== 32'h8000_0001 || nvalid != 32) begin
      n_fail++;
      $display("[TB] FAIL mix_stream: got %h (%0d bits) required 80000001 (32 bits)", stream,
               nvalid);
    end
    tick();
    tick();
    n_cmp++;
    if ({SERIAL_VALID, BUSY} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL mix_idle: got val/busy=%b required 00", {SERIAL_VALID, BUSY});
    end
  endtask

  task automatic test_mid_word_reset();
    PAR_IN = 16'hFFFF;
    LSB_FIRST = 1'b1;
    PAR_VALID = 1'b1;
    tick();
    PAR_IN = 16'h0001;
    tick();
    tick();
    PAR_VALID = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++;
    if ({SERIAL_OUT, SERIAL_VALID, PAR_READY, BUSY} !== 4'b1101) begin
      n_fail++;
      $display("[TB] FAIL rst_pre: got out/val/rdy/busy=%b required 1101",
               {SERIAL_OUT, SERIAL_VALID, PAR_READY, BUSY});
    end
    RESET = 1'b1;
    PAR_VALID = 1'b1;
    PAR_IN = 16'h00AA;
    tick();
    RESET = 1'b0;
    PAR_VALID = 1'b0;
    n_cmp++;
    if ({SERIAL_OUT, SERIAL_VALID, FRAME_START, PAR_READY, BUSY} !== 5'b00010) begin
      n_fail++;
      $display("[TB] FAIL rst_now: got out/val/fs/rdy/busy=%b required 00010",
               {SERIAL_OUT, SERIAL_VALID, FRAME_START, PAR_READY, BUSY});
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if ({SERIAL_VALID, BUSY} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL rst_discard cyc %0d: got val/busy=%b required 00", i,
                 {SERIAL_VALID, BUSY});
        break;
      end
    end
    PAR_IN = 16'h0005;
    LSB_FIRST = 1'b1;
    PAR_VALID = 1'b1;
    tick();
    PAR_VALID = 1'b0;
    tick();
    n_cmp++;
    if ({SERIAL_OUT, SERIAL_VALID, FRAME_START} !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL rst_restart_b0: got out/val/fs=%b required 111",
               {SERIAL_OUT, SERIAL_VALID, FRAME_START});
    end
    tick();
    n_cmp++;
    if ({SERIAL_OUT, SERIAL_VALID, FRAME_START} !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL rst_restart_b1: got out/val/fs=%b required 010",
               {SERIAL_OUT, SERIAL_VALID, FRAME_START});
    end
    tick();
    n_cmp++;
    if ({SERIAL_OUT, SERIAL_VALID, FRAME_START} !== 3'b110) begin
      n_fail++;
      $display("[TB] FAIL rst_restart_b2: got out/val/fs=%b required 110",
               {SERIAL_OUT, SERIAL_VALID, FRAME_START});
    end
    for (int i = 0; i < 16; i++) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    RESET = 1'b1;
    PAR_IN = '0;
    PAR_VALID = 1'b0;
    LSB_FIRST = 1'b0;
    $display("[TB] start");
    test_reset();
    test_single_word(16'hA5C3, 1'b1, 16'b1100_0011_1010_0101);
    test_single_word(16'hA5C3, 1'b0, 16'b1010_0101_1100_0011);
    test_back_to_back();
    tick();
    tick();
    test_order_mix();
    test_mid_word_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
